pc_gen: RTL and testbench
=========================

# pc_gen

Fetch-stage program-counter generator for the 5-stage MIPS pipeline, the parametrised successor of the single-width PC register. It produces the PC each cycle and arbitrates stall, ID-stage jump, EX/MEM branch resolution, exception entry and halt. It optionally predicts branches through a direct-mapped branch target buffer (BTB). It drives instruction-memory address and the pipeline flush signals.

## Interface
- `ADDR_W`, 32: PC width in bits; must be ≥ 28.
- `RESET_VEC`, 32'h0000_0000: PC value loaded on reset.
- `EXC_VEC`, 32'h0000_0180: exception entry address.
- `BTB_DEPTH`, 16: BTB entries; must be a power of 2, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  1 = PC may advance; 0 = hold, used for load-use stall.
- `jump_id`  in  1  J/JAL decoded in ID.
- `instr_index_id`  in  26  J-format instruction index.
- `pc_id`  in  ADDR_W  PC of the instruction in ID.
- `res_valid`  in  1  EX/MEM holds a resolved conditional branch.
- `res_taken`  in  1  actual branch outcome.
- `res_pred`  in  1  prediction carried down the pipe with that branch.
- `res_pc`  in  ADDR_W  PC of the resolved branch.
- `res_target`  in  ADDR_W  computed branch target.
- `exc_req`  in  1  exception request, one-cycle pulse.
- `halt_req`  in  1  enter HALT.
- `resume`  in  1  leave HALT.
- `pc`  out  ADDR_W  current fetch PC, registered.
- `pred_taken`  out  1  prediction for the instruction at `pc`.
- `flush_if_id`  out  1  kill IF/ID.
- `flush_id_ex`  out  1  kill ID/EX.
- `flush_ex_mem`  out  1  kill EX/MEM.
- `halted`  out  1  FSM is in HALT.

## Operation
- Reset (`reset`=0, asynchronous):
  - `pc`=RESET_VEC.
  - All flush outputs, `pred_taken` and `halted` = 0.
  - State = RUN.
  - BTB valid bits and counters cleared (counters to 2'b01, weakly not-taken).
- Mispredict:
  - `mispredict` = `res_valid` & (`res_taken` ≠ `res_pred`).
  - `fix_pc` = `res_taken` ? `res_target` : `res_pc`+4.
- Next-PC priority, evaluated at each rising edge of `clk`:
  1. `exc_req`: PC←EXC_VEC. Assert all three flushes. Overrides `pc_write`=0 and HALT, and returns the FSM to RUN.
  2. `mispredict`: PC←`fix_pc`. Assert `flush_if_id` and `flush_id_ex`. Overrides `pc_write`=0.
  3. `jump_id`: PC←{`pc_id`+4 upper (ADDR_W−28) bits, `instr_index_id`, 2'b00}. Assert `flush_if_id`. Ignored while `pc_write`=0.
  4. `pc_write`=0 or state HALT: PC holds.
  5. Otherwise: PC←`pc_pred`, where `pc_pred` = BTB hit & counter[1] ? BTB target : `pc`+4.
- Flush outputs are combinational from the winning source and valid in the same cycle as the redirect request.
- FSM states are RUN and HALT.
  - RUN→HALT on `halt_req` when no exception or mispredict wins that cycle. PC holds from the next edge.
  - HALT→RUN on `resume` or `exc_req`.
  - `halted`=1 in HALT.
  - A mispredict arriving in HALT still redirects the PC; the FSM stays in HALT.
- Arithmetic: all adds are modulo 2^ADDR_W. 0xFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- Redirect latency: request in cycle N → new `pc` visible after edge N+1.
- `pred_taken` is combinational from the current `pc` (BTB lookup).
- Stall: with `pc_write`=0 and no redirect, `pc` and `pred_taken` are stable.
- When `reset` deasserts, the first fetch is RESET_VEC on the first edge.

## Configuration
- Macro: `PC_GEN_BTB_EN`.
- Defined:
  - BTB has BTB_DEPTH entries of {valid, tag = `pc`[ADDR_W−1 : log2(BTB_DEPTH)+2], target, 2-bit counter}, indexed by `pc`[log2(BTB_DEPTH)+1 : 2].
  - Update happens on `res_valid` at `res_pc`'s index:
    - allocate the entry if it is invalid or the tag mismatches and `res_taken` (target = `res_target`, counter = 2'b10);
    - on a tag hit, the counter saturates toward the outcome and the target is rewritten.
  - The update takes effect at the next edge. A same-cycle lookup of the same index sees the old contents.
- Undefined: no BTB storage; `pred_taken`=0 and `pc_pred` = `pc`+4, so every taken branch mispredicts.

## Structure
- Package `pc_gen_pkg` holds:
  - the FSM state enum {RUN, HALT};
  - the BTB entry struct;
  - 2-bit counter constants SNT=00, WNT=01, WT=10, ST=11;
  - the default vector constants.
- One sub-module `pc_btb`: storage, lookup and update, instantiated only under `PC_GEN_BTB_EN`.

## Test plan
- Reset: deassert `reset` → first `pc` after the edge = 0x0, then 0x4, 0x8. Assert `reset` mid-run → `pc`=0x0 immediately, without waiting for a clock edge.
- Stall vs redirect: `pc_write`=0 with `jump_id`=1, `instr_index_id`=0x40 → `pc` holds. Same with `mispredict` (`res_taken`=1, `res_pred`=0, `res_target`=0x200) → `pc`=0x200, and `flush_if_id`=`flush_id_ex`=1.
- Priority: `exc_req`, `mispredict` and `jump_id` in the same cycle → `pc`=0x180 and all three flushes = 1.
- Jump: `pc_id`=0x1000_0010, `instr_index_id`=0x000_0100 → `pc`=0x1000_0400 and `flush_if_id`=1 only.
- BTB (macro on):
  - Branch at 0x40, taken to 0x80, resolved once → next fetch of 0x40 gives `pred_taken`=1 and `pc` 0x80.
  - Resolved not-taken twice → `pred_taken`=0 at 0x40.
  - With the macro off → `pred_taken` is always 0.
- Halt: `halt_req` at `pc`=0x20 → `pc` frozen and `halted`=1. `resume` → 0x24 on the next edge. `exc_req` during HALT → `pc`=0x180 and `halted`=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
//   - state_t      : RUN / HALT FSM states (legacy 1-bit encodings kept as
//                    localparam constants ST_RUN / ST_HALT)
//   - ctr_t        : 2-bit branch counter, constants SNT/WNT/WT/ST
//   - btb_entry_t  : one BTB line {valid, tag, target, ctr}; tag and target
//                    are stored zero-extended to BTB_FIELD_W bits so that the
//                    struct does not depend on the PC width parameter
//   - ctr_update() : saturating counter step toward a branch outcome
//   - DEF_RESET_VEC / DEF_EXC_VEC : default reset and exception vectors
package pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef enum logic [0:0] {
        RUN  = ST_RUN,
        HALT = ST_HALT
    } state_t;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    localparam int unsigned BTB_FIELD_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        ctr_t                   ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the pipeline and pc_gen.
//   Inputs to pc_gen : pc_write, jump_id, instr_index_id, pc_id, res_valid,
//                      res_taken, res_pred, res_pc, res_target, exc_req,
//                      halt_req, resume
//   Outputs          : pc, pred_taken, flush_if_id, flush_id_ex,
//                      flush_ex_mem, halted
//   modport slave  : pc_gen side
//   modport master : pipeline / testbench side
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              pc_write;
    logic              jump_id;
    logic [25:0]       instr_index_id;
    logic [ADDR_W-1:0] pc_id;
    logic              res_valid;
    logic              res_taken;
    logic              res_pred;
    logic [ADDR_W-1:0] res_pc;
    logic [ADDR_W-1:0] res_target;
    logic              exc_req;
    logic              halt_req;
    logic              resume;

    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic              halted;

    modport slave (
        input  pc_write, jump_id, instr_index_id, pc_id,
        input  res_valid, res_taken, res_pred, res_pc, res_target,
        input  exc_req, halt_req, resume,
        output pc, pred_taken, flush_if_id, flush_id_ex, flush_ex_mem, halted
    );

    modport master (
        output pc_write, jump_id, instr_index_id, pc_id,
        output res_valid, res_taken, res_pred, res_pc, res_target,
        output exc_req, halt_req, resume,
        input  pc, pred_taken, flush_if_id, flush_id_ex, flush_ex_mem, halted
    );
endinterface

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer used by pc_gen when the
// PC_GEN_BTB_EN macro is defined.
//   clk, reset    : clock, asynchronous active-low reset (clears valid bits,
//                   counters to WNT)
//   lookup_word   : fetch PC without its two byte-offset bits
//   pred_taken    : lookup hit with counter in a taken state
//   pred_target   : stored target of the looked-up line
//   upd_en        : a conditional branch has resolved this cycle
//   upd_word      : resolved branch PC without byte-offset bits
//   upd_taken     : actual outcome
//   upd_target    : computed branch target
// Updates land at the next edge, so a lookup of the same line in the update
// cycle returns the old contents.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-3:0] lookup_word,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-3:0] upd_word,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

    btb_entry_t mem [BTB_DEPTH];

    logic [IDX_W-1:0]       lk_idx;
    logic [BTB_FIELD_W-1:0] lk_tag;
    btb_entry_t             lk;
    logic [IDX_W-1:0]       up_idx;
    logic [BTB_FIELD_W-1:0] up_tag;
    btb_entry_t             up;
    logic                   up_hit;

    always_comb begin
        lk_idx      = lookup_word[IDX_W-1:0];
        lk_tag      = BTB_FIELD_W'(lookup_word[ADDR_W-3:IDX_W]);
        lk          = mem[lk_idx];
        pred_taken  = lk.valid && (lk.tag == lk_tag) && lk.ctr[1];
        pred_target = lk.target[ADDR_W-1:0];
    end

    always_comb begin
        up_idx = upd_word[IDX_W-1:0];
        up_tag = BTB_FIELD_W'(upd_word[ADDR_W-3:IDX_W]);
        up     = mem[up_idx];
        up_hit = up.valid && (up.tag == up_tag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
                mem[i].valid  <= 1'b0;
                mem[i].tag    <= '0;
                mem[i].target <= '0;
                mem[i].ctr    <= WNT;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                mem[up_idx].ctr    <= ctr_update(up.ctr, upd_taken);
                mem[up_idx].target <= BTB_FIELD_W'(upd_target);
            end else if (upd_taken) begin
                // Only taken branches earn a line; a not-taken miss leaves
                // whatever lives there untouched.
                mem[up_idx] <= '{valid:  1'b1,
                                 tag:    up_tag,
                                 target: BTB_FIELD_W'(upd_target),
                                 ctr:    WT};
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator for the 5-stage MIPS pipe.
//   clk    : clock
//   reset  : asynchronous, active-low reset (pc <= RESET_VEC, FSM -> RUN)
//   bus    : pc_gen_if.slave carrying stall, ID jump, EX/MEM branch
//            resolution, exception, halt/resume inputs and the pc,
//            pred_taken, flush_* and halted outputs
// Next-PC priority: exception > mispredict > jump (needs pc_write) >
// hold (stall or HALT) > predicted/sequential PC.
// Optional macro PC_GEN_BTB_EN adds the pc_btb branch predictor; without
// it pred_taken is 0 and the predicted PC is always pc+4.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int unsigned       BTB_DEPTH = 16
) (
    input logic     clk,
    input logic     reset,
    pc_gen_if.slave bus
);

    if (ADDR_W < 28) begin : g_bad_addr_w
        $error("pc_gen: ADDR_W must be at least 28");
    end
    if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_gen: BTB_DEPTH must be a power of two, at least 2");
    end

    // Keeps the upper ADDR_W-28 bits of pc_id+4 for J-format targets;
    // written as a shift so ADDR_W == 28 needs no zero-width slice.
    localparam logic [ADDR_W-1:0] JUMP_HI_MASK = {ADDR_W{1'b1}} << 28;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_pred;
    logic [ADDR_W-1:0] fix_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] btb_target;
    logic              btb_taken;
    logic              mispredict;
    logic              f_if_id;
    logic              f_id_ex;
    logic              f_ex_mem;
    state_t            state_q;
    state_t            state_next;

`ifdef PC_GEN_BTB_EN
    pc_btb #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_word (pc_q[ADDR_W-1:2]),
        .pred_taken  (btb_taken),
        .pred_target (btb_target),
        .upd_en      (bus.res_valid),
        .upd_word    (bus.res_pc[ADDR_W-1:2]),
        .upd_taken   (bus.res_taken),
        .upd_target  (bus.res_target)
    );
`else
    assign btb_taken  = 1'b0;
    assign btb_target = '0;
`endif

    always_comb begin
        pc_plus4   = pc_q + ADDR_W'(4);
        pc_pred    = btb_taken ? btb_target : pc_plus4;
        mispredict = bus.res_valid && (bus.res_taken != bus.res_pred);
        fix_pc     = bus.res_taken ? bus.res_target : bus.res_pc + ADDR_W'(4);
        jump_pc    = ((bus.pc_id + ADDR_W'(4)) & JUMP_HI_MASK)
                   | ADDR_W'({bus.instr_index_id, 2'b00});
    end

    always_comb begin
        pc_next    = pc_q;
        state_next = state_q;
        f_if_id    = 1'b0;
        f_id_ex    = 1'b0;
        f_ex_mem   = 1'b0;
        // Flushes are combinational from the inputs; gate them so nothing
        // leaks out while reset is held.
        if (reset) begin
            if (bus.exc_req) begin
                pc_next    = EXC_VEC;
                state_next = RUN;
                f_if_id    = 1'b1;
                f_id_ex    = 1'b1;
                f_ex_mem   = 1'b1;
            end else if (mispredict) begin
                // Redirects even from HALT; the FSM stays where it is.
                pc_next = fix_pc;
                f_if_id = 1'b1;
                f_id_ex = 1'b1;
            end else begin
                if (bus.jump_id && bus.pc_write) begin
                    pc_next = jump_pc;
                    f_if_id = 1'b1;
                end else if (bus.pc_write && state_q == RUN) begin
                    pc_next = pc_pred;
                end
                // Halt entry takes effect from the following edge, so the
                // PC still moves on the edge that accepts halt_req.
                if (state_q == RUN && bus.halt_req) begin
                    state_next = HALT;
                end else if (state_q == HALT && bus.resume) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_next;
            state_q <= state_next;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pred_taken   = btb_taken;
    assign bus.flush_if_id  = f_if_id;
    assign bus.flush_id_ex  = f_id_ex;
    assign bus.flush_ex_mem = f_ex_mem;
    assign bus.halted       = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen. The stimulus process computes the
// expected outputs of each cycle from a behavioural model (plain arithmetic
// and per-line arrays for the BTB) and queues them; a monitor on the falling
// edge pops and compares. Directed scenarios come first, then random traffic.
// Honours PC_GEN_BTB_EN the same way the design does.
module tb_pc_gen;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] EXC   = 32'h0000_0180;
`ifdef PC_GEN_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic clk;
    logic reset;

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000),
        .EXC_VEC   (EXC),
        .BTB_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic        f1;
        logic        f2;
        logic        f3;
        logic        h;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_v   [DEPTH];
    int unsigned m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_pc = 32'h0;
        m_halt = 0;
    endtask

    function automatic bit m_lookup(input logic [31:0] a, output logic [31:0] tgt);
        int unsigned i;
        i = (a / 4) % DEPTH;
        tgt = m_tgt[i];
        if (!BTB_ON) return 0;
        return m_v[i] && (m_tag[i] == a / (4 * DEPTH)) && (m_ctr[i] >= 2);
    endfunction

    task automatic m_update(input logic [31:0] a, input bit taken, input logic [31:0] tgt);
        int unsigned i;
        i = (a / 4) % DEPTH;
        if (!BTB_ON) return;
        if (m_v[i] && m_tag[i] == a / (4 * DEPTH)) begin
            m_ctr[i] = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                             : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            m_tgt[i] = tgt;
        end else if (taken) begin
            m_v[i] = 1; m_tag[i] = a / (4 * DEPTH); m_tgt[i] = tgt; m_ctr[i] = 2;
        end
    endtask

    task automatic clear_inputs();
        bus.pc_write = 1'b1; bus.jump_id = 1'b0; bus.instr_index_id = '0;
        bus.pc_id = '0; bus.res_valid = 1'b0; bus.res_taken = 1'b0;
        bus.res_pred = 1'b0; bus.res_pc = '0; bus.res_target = '0;
        bus.exc_req = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
    endtask

    // Called shortly after a rising edge with inputs already applied:
    // queue this cycle's expected outputs, then advance the model one edge.
    task automatic step();
        exp_t        e;
        logic [31:0] tgt, nxt, tmp;
        bit          mis, nh, rv, rt;
        logic [31:0] rpc, rtg;
        e.pc = m_pc; e.h = m_halt;
        e.pt = m_lookup(m_pc, tgt);
        e.f1 = 0; e.f2 = 0; e.f3 = 0;
        nxt = m_pc; nh = m_halt;
        rv = bus.res_valid; rt = bus.res_taken; rpc = bus.res_pc; rtg = bus.res_target;
        mis = rv && (rt != bus.res_pred);
        if (bus.exc_req) begin
            nxt = EXC; nh = 0; e.f1 = 1; e.f2 = 1; e.f3 = 1;
        end else if (mis) begin
            nxt = rt ? rtg : rpc + 32'd4; e.f1 = 1; e.f2 = 1;
        end else begin
            if (bus.jump_id && bus.pc_write) begin
                tmp = bus.pc_id + 32'd4;
                nxt = {tmp[31:28], bus.instr_index_id, 2'b00};
                e.f1 = 1;
            end else if (bus.pc_write && !m_halt) begin
                nxt = e.pt ? tgt : m_pc + 32'd4;
            end
            if (!m_halt && bus.halt_req) nh = 1;
            else if (m_halt && bus.resume) nh = 0;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (rv) m_update(rpc, rt, rtg);
        m_pc = nxt;
        m_halt = nh;
    endtask

    // Monitor: one expected record per cycle, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc",           bus.pc,           e.pc);
                chk("pred_taken",   bus.pred_taken,   e.pt);
                chk("flush_if_id",  bus.flush_if_id,  e.f1);
                chk("flush_id_ex",  bus.flush_id_ex,  e.f2);
                chk("flush_ex_mem", bus.flush_ex_mem, e.f3);
                chk("halted",       bus.halted,       e.h);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic jump_to(input logic [25:0] idx);
        clear_inputs();
        bus.jump_id = 1'b1; bus.pc_id = 32'h0; bus.instr_index_id = idx;
        step();
        clear_inputs();
    endtask

    initial begin
        bit p;
        logic [31:0] t;
        reset = 1'b0;
        clear_inputs();
        model_clear();
        // Redirect requests while in reset must not flush or move the PC.
        bus.exc_req = 1'b1; bus.jump_id = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",     bus.pc, 32'h0);
        chk("rst_flush",  {bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem}, 32'h0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_pred",   bus.pred_taken, 1'b0);
        clear_inputs();
        reset = 1'b1;

        step(); chk("run_pc4", bus.pc, 32'h4);
        step(); chk("run_pc8", bus.pc, 32'h8);

        // Stall blocks a jump
        bus.pc_write = 1'b0; bus.jump_id = 1'b1; bus.instr_index_id = 26'h40;
        step(); chk("stall_jump_hold", bus.pc, 32'h8);
        clear_inputs();

        // Stall does not block a mispredict
        bus.pc_write = 1'b0; bus.res_valid = 1'b1; bus.res_taken = 1'b1;
        bus.res_pred = 1'b0; bus.res_pc = 32'h100; bus.res_target = 32'h200;
        step(); chk("stall_mispredict", bus.pc, 32'h200);
        clear_inputs();

        // Exception beats mispredict and jump
        bus.exc_req = 1'b1; bus.res_valid = 1'b1; bus.res_taken = 1'b1;
        bus.res_pred = 1'b0; bus.res_pc = 32'h300; bus.res_target = 32'h500;
        bus.jump_id = 1'b1; bus.instr_index_id = 26'h77;
        step(); chk("priority_exc", bus.pc, EXC);
        clear_inputs();

        // J-format target keeps the upper bits of pc_id+4
        bus.jump_id = 1'b1; bus.pc_id = 32'h1000_0010; bus.instr_index_id = 26'h100;
        step(); chk("jump_target", bus.pc, 32'h1000_0400);
        clear_inputs();

        // Wrap-around: not-taken fix at the top of memory, then pc+4 wrap
        bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.res_pred = 1'b1;
        bus.res_pc = 32'hFFFF_FFFC;
        step(); chk("fix_wrap", bus.pc, 32'h0);
        clear_inputs();
        bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_pred = 1'b0;
        bus.res_pc = 32'h8; bus.res_target = 32'hFFFF_FFFC;
        step(); chk("to_top", bus.pc, 32'hFFFF_FFFC);
        clear_inputs();
        step(); chk("pc_wrap", bus.pc, 32'h0);

        // Branch predictor
        bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_pred = 1'b0;
        bus.res_pc = 32'h40; bus.res_target = 32'h80;
        step();
        clear_inputs();
        jump_to(26'h10);
        chk("btb_pred_taken", bus.pred_taken, BTB_ON);
        step(); chk("btb_follow", bus.pc, BTB_ON ? 32'h80 : 32'h44);
        repeat (2) begin
            bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.res_pred = 1'b1;
            bus.res_pc = 32'h40;
            step();
        end
        clear_inputs();
        jump_to(26'h10);
        chk("btb_pred_not_taken", bus.pred_taken, 1'b0);

        // Halt / resume / exception out of halt
        jump_to(26'h8);
        chk("at_0x20", bus.pc, 32'h20);
        bus.halt_req = 1'b1;
        step(); clear_inputs();
        chk("halt_flag", bus.halted, 1'b1);
        step(); chk("halt_frozen", bus.pc, 32'h24);
        bus.resume = 1'b1;
        step(); clear_inputs();
        chk("resume_pc", bus.pc, 32'h24);
        chk("resume_flag", bus.halted, 1'b0);
        step(); chk("after_resume", bus.pc, 32'h28);
        bus.halt_req = 1'b1;
        step(); clear_inputs();
        step();
        bus.exc_req = 1'b1;
        step(); clear_inputs();
        chk("halt_exc_pc", bus.pc, EXC);
        chk("halt_exc_flag", bus.halted, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bus.pc_write       = ($urandom_range(0, 9) != 0);
            bus.jump_id        = ($urandom_range(0, 15) == 0);
            bus.pc_id          = $urandom & 32'hF000_0FFC;
            bus.instr_index_id = 26'($urandom_range(0, 255));
            bus.res_valid      = ($urandom_range(0, 3) == 0);
            bus.res_pc         = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 3) * 4);
            bus.res_taken      = 1'($urandom_range(0, 1));
            p = m_lookup(bus.res_pc, t);
            bus.res_pred       = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : p;
            bus.res_target     = 32'($urandom_range(0, 255) * 4);
            bus.exc_req        = ($urandom_range(0, 63) == 0);
            bus.halt_req       = ($urandom_range(0, 31) == 0);
            bus.resume         = ($urandom_range(0, 7) == 0);
            step();
        end
        clear_inputs();

        // Asynchronous reset in mid-cycle
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pc",     bus.pc, 32'h0);
        chk("async_rst_halted", bus.halted, 1'b0);
        chk("async_rst_pred",   bus.pred_taken, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        step(); chk("post_rst_pc4", bus.pc, 32'h4);
        step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
